// File: rtl/power_domain_sequencer_pkg.sv
// Shared encodings for the power-domain sequencer: target levels, mode states,
// per-domain sequencer states and the mode-to-target mapping.
package power_domain_sequencer_pkg;

   typedef enum logic [1:0] {
      LvlOn    = 2'd0,
      LvlGated = 2'd1,
      LvlOff   = 2'd2
   } level_e;

   typedef enum logic [1:0] {
      PmNormal = 2'd0,
      PmIdle   = 2'd1,
      PmSleep  = 2'd2,
      PmPdown  = 2'd3
   } pm_state_e;

   typedef enum logic [2:0] {
      StOn,
      StGated,
      StIso,
      StOff,
      StSettle
   } seq_state_e;

   // keep_on only lifts a domain to ON in IDLE/SLEEP; PDOWN ignores it.
   function automatic level_e domain_target(pm_state_e st, logic keep, logic aon, logic core);
      level_e lvl;
      case (st)
         PmNormal: lvl = LvlOn;
         PmIdle:   lvl = (core || keep) ? LvlOn : LvlGated;
         PmSleep:  lvl = (core || keep) ? LvlOn : (aon ? LvlGated : LvlOff);
         default:  lvl = aon ? LvlGated : LvlOff;
      endcase
      return lvl;
   endfunction

endpackage

// File: rtl/power_domain_sequencer_if.sv
// Request/status bundle between the core-side controller and the power sequencer.
interface power_domain_sequencer_if #(
   parameter int unsigned NumDomains = 4,
   parameter int unsigned IdleCntW   = 16
);
   logic                  cpu_idle;
   logic                  halt;
   logic                  sleep_req;
   logic                  power_down_req;
   logic                  wake_event;
   logic [IdleCntW-1:0]   idle_threshold;
   logic [NumDomains-1:0] keep_on;
   logic [NumDomains-1:0] domain_clk_en;
   logic [NumDomains-1:0] domain_iso;
   logic [NumDomains-1:0] domain_pwr_en;
   logic [1:0]            pm_state;
   logic                  busy;
   logic                  wake_ack;

   modport master (
      output cpu_idle, halt, sleep_req, power_down_req, wake_event, idle_threshold, keep_on,
      input  domain_clk_en, domain_iso, domain_pwr_en, pm_state, busy, wake_ack
   );

   modport slave (
      input  cpu_idle, halt, sleep_req, power_down_req, wake_event, idle_threshold, keep_on,
      output domain_clk_en, domain_iso, domain_pwr_en, pm_state, busy, wake_ack
   );
endinterface

// File: rtl/power_domain_sequencer_domain_seq.sv
// One domain's gate/isolate/power-off walker; outputs decode straight from the state
// register so each step changes exactly one control.
module power_domain_sequencer_domain_seq
   import power_domain_sequencer_pkg::*;
#(
   parameter int unsigned SettleCycles = 8
) (
   input  logic   clk_i,
   input  logic   rst_i,
   input  level_e target_i,
   output logic   clk_en_o,
   output logic   iso_o,
   output logic   pwr_en_o,
   output logic   at_target_o
);
   localparam int unsigned SettleW = $clog2(SettleCycles + 1);

   seq_state_e         state_q, state_d;
   logic [SettleW-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StOn;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // StIso and StSettle always run to completion, whatever the target does meanwhile.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StOn:     if (target_i != LvlOn) state_d = StGated;
         StGated: begin
            if (target_i == LvlOn)       state_d = StOn;
            else if (target_i == LvlOff) state_d = StIso;
         end
         StIso:    state_d = StOff;
         StOff: begin
            if (target_i != LvlOff) begin
               state_d = StSettle;
               cnt_d   = SettleW'(SettleCycles - 1);
            end
         end
         StSettle: begin
            if (cnt_q == '0) state_d = StGated;
            else             cnt_d   = cnt_q - 1'b1;
         end
         default:  state_d = StOn;
      endcase
   end

   assign clk_en_o    = (state_q == StOn);
   assign iso_o       = (state_q == StIso) || (state_q == StOff) || (state_q == StSettle);
   assign pwr_en_o    = (state_q != StOff);
   assign at_target_o = ((state_q == StOn)    && (target_i == LvlOn))    ||
                        ((state_q == StGated) && (target_i == LvlGated)) ||
                        ((state_q == StOff)   && (target_i == LvlOff));

endmodule

// File: rtl/power_domain_sequencer.sv
// Power manager top: mode FSM and idle counter pick a per-domain target level,
// one sequencer per domain walks to it; busy/wake_ack summarise progress.
module power_domain_sequencer
   import power_domain_sequencer_pkg::*;
#(
   parameter int unsigned           NumDomains   = 4,
   parameter int unsigned           IdleCntW     = 16,
   parameter int unsigned           SettleCycles = 8,
   parameter logic [NumDomains-1:0] AlwaysOnMask = NumDomains'(1)
) (
   input logic                     clk_i,
   input logic                     rst_i,
   power_domain_sequencer_if.slave pm_io
);
   pm_state_e             state_q, state_d;
   logic [IdleCntW-1:0]   idle_cnt_q, idle_cnt_d;
   logic                  wake_pend_q, wake_pend_d;
   logic [NumDomains-1:0] clk_en, iso, pwr_en, at_target;
   logic                  idle, wake_ack;

   assign idle = pm_io.cpu_idle || pm_io.halt;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= PmNormal;
         idle_cnt_q  <= '0;
         wake_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idle_cnt_q  <= idle_cnt_d;
         wake_pend_q <= wake_pend_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      idle_cnt_d = '0;
      if (pm_io.wake_event && (state_q != PmNormal)) begin
         state_d = PmNormal;
      end else if (pm_io.power_down_req) begin
         state_d = PmPdown;
      end else if (pm_io.sleep_req && ((state_q == PmNormal) || (state_q == PmIdle))) begin
         state_d = PmSleep;
      end else begin
         unique case (state_q)
            PmNormal: begin
               if ((pm_io.idle_threshold != '0) && (idle_cnt_q == pm_io.idle_threshold)) begin
                  state_d = PmIdle;
               end else if (idle) begin
                  idle_cnt_d = (idle_cnt_q == '1) ? idle_cnt_q : idle_cnt_q + 1'b1;
               end
            end
            PmIdle:  if (!idle) state_d = PmNormal;
            PmSleep: if (!pm_io.sleep_req) state_d = PmNormal;
            default: state_d = PmNormal;
         endcase
      end
   end

   // A pending wake survives only while the mode stays NORMAL and until acknowledged.
   always_comb begin
      wake_pend_d = wake_pend_q && !wake_ack && (state_d == PmNormal);
      if (pm_io.wake_event && (state_q != PmNormal)) wake_pend_d = 1'b1;
   end

   for (genvar i = 0; i < NumDomains; i++) begin : g_dom
      level_e tgt;
      assign tgt = domain_target(state_q, pm_io.keep_on[i], AlwaysOnMask[i], (i == 0));

      power_domain_sequencer_domain_seq #(
         .SettleCycles (SettleCycles)
      ) u_seq (
         .clk_i       (clk_i),
         .rst_i       (rst_i),
         .target_i    (tgt),
         .clk_en_o    (clk_en[i]),
         .iso_o       (iso[i]),
         .pwr_en_o    (pwr_en[i]),
         .at_target_o (at_target[i])
      );
   end

   // In NORMAL every target is ON, so all-at-target means every domain is fully up.
   assign wake_ack = wake_pend_q && (state_q == PmNormal) && (&at_target);

   assign pm_io.domain_clk_en = clk_en;
   assign pm_io.domain_iso    = iso;
   assign pm_io.domain_pwr_en = pwr_en;
   assign pm_io.pm_state      = state_q;
   assign pm_io.busy          = ~(&at_target);
   assign pm_io.wake_ack      = wake_ack;

endmodule

// File: tb/tb_power_domain_sequencer.sv
// Directed bench for power_domain_sequencer: hand-timed scenarios plus per-cycle
// checks of the clock/isolation/power ordering rules.
module tb_power_domain_sequencer;
   localparam int unsigned ND  = 4;
   localparam int unsigned ICW = 16;

   logic clk = 1'b0;
   logic rst;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   power_domain_sequencer_if #(.NumDomains(ND), .IdleCntW(ICW)) pm_if ();

   power_domain_sequencer #(
      .NumDomains   (ND),
      .IdleCntW     (ICW),
      .SettleCycles (8),
      .AlwaysOnMask (4'b0001)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .pm_io (pm_if)
   );

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         for (int d = 0; d < ND; d++) begin
            if ((!pm_if.domain_pwr_en[d] && (!pm_if.domain_iso[d] || pm_if.domain_clk_en[d])) ||
                (pm_if.domain_clk_en[d] && pm_if.domain_iso[d])) begin
               miscompares++;
               $display("FAIL invariant dom%0d got clk=%b iso=%b pwr=%b", d,
                        pm_if.domain_clk_en[d], pm_if.domain_iso[d], pm_if.domain_pwr_en[d]);
            end
         end
      end
   end

   task automatic test_reset();
      tick(3);
      rst = 1'b0;
      vectors++; if (pm_if.pm_state !== 2'd0) begin miscompares++;
         $display("FAIL reset_state got %0d want 0", pm_if.pm_state); end
      vectors++; if ({pm_if.domain_clk_en, pm_if.domain_iso, pm_if.domain_pwr_en} !== 12'hF0F) begin
         miscompares++; $display("FAIL reset_outs got %b/%b/%b want 1111/0000/1111",
            pm_if.domain_clk_en, pm_if.domain_iso, pm_if.domain_pwr_en); end
      vectors++; if ({pm_if.busy, pm_if.wake_ack} !== 2'b00) begin miscompares++;
         $display("FAIL reset_flags got %b%b want 00", pm_if.busy, pm_if.wake_ack); end
   endtask

   task automatic test_idle();
      pm_if.idle_threshold = 16'd5;
      pm_if.cpu_idle = 1'b1;
      tick(5);
      vectors++; if (pm_if.pm_state !== 2'd0) begin miscompares++;
         $display("FAIL idle_early got %0d want 0", pm_if.pm_state); end
      tick(1);
      vectors++; if (pm_if.pm_state !== 2'd1 || pm_if.busy !== 1'b1) begin miscompares++;
         $display("FAIL idle_enter got st=%0d busy=%b want st=1 busy=1", pm_if.pm_state, pm_if.busy); end
      tick(1);
      vectors++; if ({pm_if.domain_clk_en, pm_if.domain_iso, pm_if.domain_pwr_en, pm_if.busy} !==
                     {4'b0001, 4'b0000, 4'b1111, 1'b0}) begin miscompares++;
         $display("FAIL idle_outs got %b/%b/%b busy=%b want 0001/0000/1111 busy=0",
            pm_if.domain_clk_en, pm_if.domain_iso, pm_if.domain_pwr_en, pm_if.busy); end
      pm_if.cpu_idle = 1'b0;
      pm_if.idle_threshold = 16'd0;
      tick(1);
      vectors++; if (pm_if.pm_state !== 2'd0) begin miscompares++;
         $display("FAIL idle_exit got %0d want 0", pm_if.pm_state); end
      tick(1);
      vectors++; if (pm_if.domain_clk_en !== 4'b1111 || pm_if.wake_ack !== 1'b0) begin miscompares++;
         $display("FAIL idle_back got clk=%b ack=%b want 1111 0", pm_if.domain_clk_en, pm_if.wake_ack); end
   endtask

   task automatic test_sleep();
      pm_if.sleep_req = 1'b1;
      tick(1);
      vectors++; if (pm_if.pm_state !== 2'd2) begin miscompares++;
         $display("FAIL sleep_enter got %0d want 2", pm_if.pm_state); end
      tick(2);
      vectors++; if ({pm_if.domain_clk_en, pm_if.domain_iso, pm_if.domain_pwr_en} !==
                     {4'b0001, 4'b1110, 4'b1111}) begin miscompares++;
         $display("FAIL sleep_mid got %b/%b/%b want 0001/1110/1111",
            pm_if.domain_clk_en, pm_if.domain_iso, pm_if.domain_pwr_en); end
      tick(1);
      vectors++; if ({pm_if.domain_clk_en, pm_if.domain_iso, pm_if.domain_pwr_en, pm_if.busy} !==
                     {4'b0001, 4'b1110, 4'b0001, 1'b0}) begin miscompares++;
         $display("FAIL sleep_done got %b/%b/%b busy=%b want 0001/1110/0001 busy=0",
            pm_if.domain_clk_en, pm_if.domain_iso, pm_if.domain_pwr_en, pm_if.busy); end
   endtask

   task automatic test_wake();
      pm_if.wake_event = 1'b1;
      pm_if.sleep_req = 1'b0;
      tick(1);
      pm_if.wake_event = 1'b0;
      vectors++; if (pm_if.pm_state !== 2'd0) begin miscompares++;
         $display("FAIL wake_state got %0d want 0", pm_if.pm_state); end
      tick(1);
      vectors++; if ({pm_if.domain_pwr_en, pm_if.domain_iso, pm_if.busy} !== {4'b1111, 4'b1110, 1'b1})
         begin miscompares++; $display("FAIL wake_pwr got pwr=%b iso=%b busy=%b want 1111 1110 1",
            pm_if.domain_pwr_en, pm_if.domain_iso, pm_if.busy); end
      tick(7);
      vectors++; if (pm_if.domain_iso !== 4'b1110) begin miscompares++;
         $display("FAIL wake_settle got iso=%b want 1110", pm_if.domain_iso); end
      tick(1);
      vectors++; if ({pm_if.domain_iso, pm_if.domain_clk_en, pm_if.wake_ack} !== {4'b0000, 4'b0001, 1'b0})
         begin miscompares++; $display("FAIL wake_iso got iso=%b clk=%b ack=%b want 0000 0001 0",
            pm_if.domain_iso, pm_if.domain_clk_en, pm_if.wake_ack); end
      tick(1);
      vectors++; if ({pm_if.domain_clk_en, pm_if.wake_ack, pm_if.busy} !== {4'b1111, 1'b1, 1'b0})
         begin miscompares++; $display("FAIL wake_ack got clk=%b ack=%b busy=%b want 1111 1 0",
            pm_if.domain_clk_en, pm_if.wake_ack, pm_if.busy); end
      tick(1);
      vectors++; if (pm_if.wake_ack !== 1'b0) begin miscompares++;
         $display("FAIL wake_ack_pulse got %b want 0", pm_if.wake_ack); end
   endtask

   task automatic test_keep_on_pdown();
      int pulses = 0;
      pm_if.keep_on = 4'b0100;
      pm_if.sleep_req = 1'b1;
      tick(4);
      vectors++; if ({pm_if.domain_clk_en, pm_if.domain_iso, pm_if.domain_pwr_en} !==
                     {4'b0101, 4'b1010, 4'b0101}) begin miscompares++;
         $display("FAIL keep_on_sleep got %b/%b/%b want 0101/1010/0101",
            pm_if.domain_clk_en, pm_if.domain_iso, pm_if.domain_pwr_en); end
      pm_if.power_down_req = 1'b1;
      tick(4);
      vectors++; if ({pm_if.pm_state, pm_if.domain_clk_en, pm_if.domain_iso, pm_if.domain_pwr_en,
                      pm_if.busy} !== {2'd3, 4'b0000, 4'b1110, 4'b0001, 1'b0}) begin miscompares++;
         $display("FAIL pdown got st=%0d %b/%b/%b busy=%b want 3 0000/1110/0001 0", pm_if.pm_state,
            pm_if.domain_clk_en, pm_if.domain_iso, pm_if.domain_pwr_en, pm_if.busy); end
      pm_if.power_down_req = 1'b0;
      pm_if.sleep_req = 1'b0;
      pm_if.keep_on = 4'b0000;
      for (int i = 0; i < 11; i++) begin
         tick(1);
         if (pm_if.wake_ack === 1'b1) pulses++;
      end
      vectors++; if ({pm_if.domain_clk_en, pm_if.domain_iso, pm_if.domain_pwr_en, pm_if.busy} !==
                     {4'b1111, 4'b0000, 4'b1111, 1'b0}) begin miscompares++;
         $display("FAIL pdown_exit got %b/%b/%b busy=%b want 1111/0000/1111 0",
            pm_if.domain_clk_en, pm_if.domain_iso, pm_if.domain_pwr_en, pm_if.busy); end
      vectors++; if (pulses !== 0) begin miscompares++;
         $display("FAIL pdown_no_ack got %0d pulses want 0", pulses); end
   endtask

   task automatic test_settle_reassert();
      pm_if.sleep_req = 1'b1;
      tick(4);
      vectors++; if (pm_if.domain_pwr_en !== 4'b0001) begin miscompares++;
         $display("FAIL sr_down got pwr=%b want 0001", pm_if.domain_pwr_en); end
      pm_if.sleep_req = 1'b0;
      tick(4);
      pm_if.sleep_req = 1'b1;
      tick(5);
      vectors++; if ({pm_if.pm_state, pm_if.domain_iso, pm_if.domain_pwr_en} !== {2'd2, 4'b1110, 4'b1111})
         begin miscompares++; $display("FAIL sr_no_early got st=%0d iso=%b pwr=%b want 2 1110 1111",
            pm_if.pm_state, pm_if.domain_iso, pm_if.domain_pwr_en); end
      tick(1);
      vectors++; if ({pm_if.domain_iso, pm_if.domain_clk_en} !== {4'b0000, 4'b0001}) begin miscompares++;
         $display("FAIL sr_settle_done got iso=%b clk=%b want 0000 0001",
            pm_if.domain_iso, pm_if.domain_clk_en); end
      tick(1);
      vectors++; if ({pm_if.domain_iso, pm_if.domain_pwr_en} !== {4'b1110, 4'b1111}) begin miscompares++;
         $display("FAIL sr_reiso got iso=%b pwr=%b want 1110 1111", pm_if.domain_iso, pm_if.domain_pwr_en); end
      tick(1);
      vectors++; if ({pm_if.domain_pwr_en, pm_if.busy} !== {4'b0001, 1'b0}) begin miscompares++;
         $display("FAIL sr_off got pwr=%b busy=%b want 0001 0", pm_if.domain_pwr_en, pm_if.busy); end
   endtask

   task automatic test_reset_mid();
      pm_if.sleep_req = 1'b0;
      tick(11);
      vectors++; if (pm_if.domain_clk_en !== 4'b1111) begin miscompares++;
         $display("FAIL rm_up got clk=%b want 1111", pm_if.domain_clk_en); end
      pm_if.sleep_req = 1'b1;
      tick(3);
      vectors++; if ({pm_if.domain_iso, pm_if.domain_pwr_en} !== {4'b1110, 4'b1111}) begin miscompares++;
         $display("FAIL rm_mid got iso=%b pwr=%b want 1110 1111", pm_if.domain_iso, pm_if.domain_pwr_en); end
      rst = 1'b1;
      pm_if.sleep_req = 1'b0;
      tick(1);
      vectors++; if ({pm_if.pm_state, pm_if.domain_clk_en, pm_if.domain_iso, pm_if.domain_pwr_en,
                      pm_if.busy, pm_if.wake_ack} !== {2'd0, 4'b1111, 4'b0000, 4'b1111, 2'b00}) begin
         miscompares++; $display("FAIL rm_reset got st=%0d %b/%b/%b busy=%b ack=%b want 0 1111/0000/1111 0 0",
            pm_if.pm_state, pm_if.domain_clk_en, pm_if.domain_iso, pm_if.domain_pwr_en,
            pm_if.busy, pm_if.wake_ack); end
      rst = 1'b0;
   endtask

   task automatic test_back_to_back();
      pm_if.halt = 1'b1;
      pm_if.idle_threshold = 16'd1;
      tick(2);
      vectors++; if (pm_if.pm_state !== 2'd1) begin miscompares++;
         $display("FAIL halt_idle got %0d want 1", pm_if.pm_state); end
      tick(1);
      pm_if.wake_event = 1'b1;
      tick(1);
      pm_if.wake_event = 1'b0;
      pm_if.halt = 1'b0;
      pm_if.idle_threshold = 16'd0;
      vectors++; if ({pm_if.pm_state, pm_if.busy, pm_if.wake_ack} !== {2'd0, 1'b1, 1'b0}) begin
         miscompares++; $display("FAIL idle_wake got st=%0d busy=%b ack=%b want 0 1 0",
            pm_if.pm_state, pm_if.busy, pm_if.wake_ack); end
      tick(1);
      vectors++; if ({pm_if.domain_clk_en, pm_if.wake_ack, pm_if.busy} !== {4'b1111, 1'b1, 1'b0}) begin
         miscompares++; $display("FAIL idle_wake_ack got clk=%b ack=%b busy=%b want 1111 1 0",
            pm_if.domain_clk_en, pm_if.wake_ack, pm_if.busy); end
      tick(1);
      vectors++; if ({pm_if.pm_state, pm_if.wake_ack} !== {2'd0, 1'b0}) begin miscompares++;
         $display("FAIL idle_wake_end got st=%0d ack=%b want 0 0", pm_if.pm_state, pm_if.wake_ack); end
   endtask

   task automatic test_pdown_priority();
      pm_if.sleep_req = 1'b1;
      pm_if.power_down_req = 1'b1;
      tick(1);
      vectors++; if (pm_if.pm_state !== 2'd3) begin miscompares++;
         $display("FAIL prio got %0d want 3", pm_if.pm_state); end
      tick(1);
      vectors++; if (pm_if.domain_clk_en !== 4'b0000) begin miscompares++;
         $display("FAIL prio_gate got clk=%b want 0000", pm_if.domain_clk_en); end
      pm_if.sleep_req = 1'b0;
      pm_if.power_down_req = 1'b0;
      tick(12);
      vectors++; if ({pm_if.pm_state, pm_if.domain_clk_en, pm_if.busy} !== {2'd0, 4'b1111, 1'b0}) begin
         miscompares++; $display("FAIL prio_exit got st=%0d clk=%b busy=%b want 0 1111 0",
            pm_if.pm_state, pm_if.domain_clk_en, pm_if.busy); end
   endtask

   initial begin
      rst = 1'b1;
      pm_if.cpu_idle = 1'b0;
      pm_if.halt = 1'b0;
      pm_if.sleep_req = 1'b0;
      pm_if.power_down_req = 1'b0;
      pm_if.wake_event = 1'b0;
      pm_if.idle_threshold = '0;
      pm_if.keep_on = '0;
      test_reset();
      test_idle();
      test_sleep();
      test_wake();
      test_keep_on_pdown();
      test_settle_reassert();
      test_reset_mid();
      test_back_to_back();
      test_pdown_priority();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
